cd_spi_csr: RTL and testbench
=============================

# cd_spi_csr

SPI slave front-end that converts host SPI frames into single-cycle CSR reads and writes on the controller's 5-bit/8-bit CSR port. It sits directly upstream of the CSR block: it drives `csr_address`, `csr_read`, `csr_write` and `csr_writedata`, and it serialises the combinational `csr_readdata` back to the host. The SPI pins are oversampled in the system clock domain, so the block has no second clock.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `sck`, `nss` and `mosi`; legal range 2..3.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sck` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `nss` in 1: SPI chip select, active low, asynchronous.
- `mosi` in 1: host data, MSB first.
- `miso` out 1: slave data, MSB first.
- `miso_oe` out 1: output enable for the `miso` pad.
- `csr_address` out 5: CSR register address.
- `csr_read` out 1: one-cycle read strobe.
- `csr_readdata` in 8: combinational read data from the CSR block.
- `csr_write` out 1: one-cycle write strobe.
- `csr_writedata` out 8: write data, valid while `csr_write`=1.

## Operation
- Frame format: the frame opens with the falling edge of `nss`. Byte 0 is the command: bit7=1 means write, bit7=0 means read; bits[4:0] are the address; bits[6:5] are ignored. All following bytes are data.
- FSM states:
  - IDLE: `nss` is high.
  - CMD: shifting byte 0.
  - DATA: shifting data bytes.
- FSM transitions:
  - IDLE→CMD on synchronised `nss` fall; `bit_cnt`=0.
  - CMD→DATA after the 8th `sck` rise; `csr_address` loads cmd[4:0] and the direction bit is latched.
  - Any state→IDLE on synchronised `nss` rise. A partial byte is discarded, and no strobe is issued for it.
- `mosi` is sampled on the detected `sck` rise. `miso` shifts on the detected `sck` fall.
- Write byte: at the 8th rise, `csr_writedata` takes the assembled byte and `csr_write` is high for exactly one cycle.
- Read byte:
  - Before the first rise of each data byte, `miso` follows `csr_readdata[7]` combinationally.
  - On the first rise, `csr_read` pulses for one cycle, and the shifter loads `csr_readdata` in that same cycle. This captures the pre-strobe value.
  - Bits 6..0 are then shifted on the following falls.
  - A read is issued only when the host clocks a data byte, so there is no prefetch and no extra read-pointer advance.
- During CMD, and during write frames, `miso` drives 0.
- `miso_oe` is the synchronised `~nss`.
- `csr_address` holds its value after a frame ends.
- Arithmetic:
  - `bit_cnt` is 3 bits and wraps 7→0 at each byte boundary.
  - When the address increments (see Configuration), it is 5 bits and wraps 0x1f→0x00.
- Simultaneous events: when an `nss` rise and an `sck` edge are detected in the same cycle, the `nss` rise wins and no strobe is issued.
- Reset values:
  - `miso`=0, `miso_oe`=0.
  - `csr_address`=0, `csr_read`=0, `csr_write`=0, `csr_writedata`=0.
  - FSM=IDLE, `bit_cnt`=0.
- Reset asserted mid-frame: all outputs return to reset values at once. After release, the block waits in IDLE until a fresh `nss` fall.

## Timing
- Edge detection is on the synchronised signals. Pin-to-action latency is SYNC_STAGES+1 `clk` cycles.
- `sck` high time and low time must each be ≥ SYNC_STAGES+2 `clk` cycles. With the default this means `sck` ≤ `clk`/8.
- `nss` fall to first `sck` rise must be ≥ SYNC_STAGES+2 `clk` cycles.
- Last `sck` fall to `nss` rise must be ≥ SYNC_STAGES+2 `clk` cycles.
- `csr_write` goes high SYNC_STAGES+1 cycles after the 8th rise on the pin.
- `csr_read` goes high SYNC_STAGES+1 cycles after the first rise of a data byte.
- At most one strobe is active per cycle, and strobes are never back-to-back.

## Configuration
- `CD_SPI_ADDR_INC_EN`:
  - Defined: after each data-byte strobe, `csr_address` increments by 1, except when the address is 0x14 (RX) or 0x15 (TX). Those two stay fixed so the host can stream FIFO data.
  - Undefined: `csr_address` stays fixed for the whole frame.

## Structure
- Shared package:
  - FSM state enum.
  - Command field positions: `CMD_WR_BIT`=7, `CMD_ADDR_MSB`=4.
  - Streaming addresses `REG_RX`=0x14, `REG_TX`=0x15.
- Sub-module `cd_sync`: a parameterised SYNC_STAGES flop chain with reset value 1 for `nss` and 0 for `sck` and `mosi`. It is instantiated three times.

## Test plan
- Write frame 0x84, 0x5a → one `csr_write` with `csr_address`=0x04 and `csr_writedata`=0x5a. No `csr_read` occurs.
- Read frame 0x0c, one dummy byte, with `csr_readdata`=0xc3 → `miso` returns 0xc3 and exactly one `csr_read` pulses.
- Streaming write frame 0x95, 0x11, 0x22, 0x33 → three writes, all to 0x15, with data 0x11, 0x22, 0x33.
- `CD_SPI_ADDR_INC_EN` defined: frame 0x8c plus 4 bytes → writes go to addresses 0x0c, 0x0d, 0x0e, 0x0f. Undefined: all four writes go to 0x0c.
- `nss` rises after 5 bits of a data byte → no strobe, FSM returns to IDLE, and the next frame decodes correctly.
- `reset_n` asserted during the 3rd bit of a write → all outputs are 0 immediately, and no `csr_write` is issued after release.

Source files
------------

// File: rtl/cd_spi_csr_pkg.sv
// Shared types and constants for the cd_spi_csr SPI-to-CSR bridge.
package cd_spi_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 4;

    localparam logic [4:0] REG_RX = 5'h14;
    localparam logic [4:0] REG_TX = 5'h15;

    // FIFO ports keep their address so a frame can stream many bytes through them.
    function automatic logic addr_is_stream(input logic [4:0] addr);
        return (addr == REG_RX) || (addr == REG_TX);
    endfunction

endpackage

// File: rtl/cd_sync.sv
// Reset-valued flop chain that brings one asynchronous SPI pin into the clk domain.
module cd_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cd_spi_csr.sv
// SPI mode-0 slave that turns host frames into single-cycle CSR reads/writes.
// Optional feature: define CD_SPI_ADDR_INC_EN to auto-increment the address per data byte.
module cd_spi_csr
    import cd_spi_csr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       nss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata
);

    localparam logic [2:0] FLUSH_DONE = 3'(SYNC_STAGES + 1);

    logic       sck_s, nss_s, mosi_s;
    logic       sck_d, nss_d;
    logic       armed;
    logic [2:0] flush_cnt;
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       is_wr;
    logic [7:0] byte_in;
    logic       sck_rise, sck_fall, nss_rise, nss_fall;

    cd_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d(sck), .q(sck_s));
    cd_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
        .clk(clk), .reset_n(reset_n), .d(nss), .q(nss_s));
    cd_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s));

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign nss_rise = nss_s & ~nss_d;
    assign nss_fall = ~nss_s & nss_d;
    assign byte_in  = {shift_in[6:0], mosi_s};
    assign miso_oe  = ~nss_s;

    always_comb begin
        miso = 1'b0;
        if (state == ST_DATA && !is_wr) begin
            miso = (bit_cnt == 3'd0) ? csr_readdata[7] : shift_out[7];
        end
    end

    // The synchroniser reset value looks like nss high; a pin held low through reset
    // would fake a fall, so frames are only accepted once a real nss high has been seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_d         <= 1'b0;
            nss_d         <= 1'b1;
            armed         <= 1'b0;
            flush_cnt     <= 3'd0;
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            shift_in      <= 8'h00;
            shift_out     <= 8'h00;
            is_wr         <= 1'b0;
            csr_address   <= 5'h00;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= 8'h00;
        end else begin
            sck_d     <= sck_s;
            nss_d     <= nss_s;
            csr_read  <= 1'b0;
            csr_write <= 1'b0;

            if (flush_cnt != FLUSH_DONE) begin
                flush_cnt <= flush_cnt + 3'd1;
            end else if (nss_d) begin
                armed <= 1'b1;
            end

`ifdef CD_SPI_ADDR_INC_EN
            if ((csr_read || csr_write) && !addr_is_stream(csr_address)) begin
                csr_address <= csr_address + 5'd1;
            end
`endif

            if (nss_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (nss_fall && armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift_in <= byte_in;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state       <= ST_DATA;
                                csr_address <= byte_in[CMD_ADDR_MSB:0];
                                is_wr       <= byte_in[CMD_WR_BIT];
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            shift_in <= byte_in;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (is_wr && bit_cnt == 3'd7) begin
                                csr_write     <= 1'b1;
                                csr_writedata <= byte_in;
                            end
                            // Capture read data in the same cycle the strobe is launched.
                            if (!is_wr && bit_cnt == 3'd0) begin
                                csr_read  <= 1'b1;
                                shift_out <= csr_readdata;
                            end
                        end else if (sck_fall && !is_wr) begin
                            shift_out <= {shift_out[6:0], 1'b0};
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cd_spi_csr.sv
// Directed bench for cd_spi_csr: bit-banged SPI host plus a CSR strobe monitor.
module tb_cd_spi_csr;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sck = 1'b0;
    logic       nss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata = 8'hc3;
    logic       csr_write;
    logic [7:0] csr_writedata;

    int checks = 0;
    int errors = 0;

    logic [4:0] wa[$];
    logic [7:0] wd[$];
    int         rd_cnt = 0;
    int         bad = 0;
    logic       prev_w = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] rx;

    cd_spi_csr #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .nss(nss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .csr_address(csr_address),
        .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (csr_write) begin
                wa.push_back(csr_address);
                wd.push_back(csr_writedata);
            end
            if (csr_read) rd_cnt++;
            if ((csr_write && prev_w) || (csr_read && prev_r) || (csr_write && csr_read)) bad++;
            prev_w = csr_write;
            prev_r = csr_read;
        end else begin
            prev_w = 1'b0;
            prev_r = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            r[i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic begin_frame();
        wa.delete();
        wd.delete();
        rd_cnt = 0;
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_addr", csr_address, 5'h00);
        chk("rst_read", csr_read, 1'b0);
        chk("rst_write", csr_write, 1'b0);
        chk("rst_wdata", csr_writedata, 8'h00);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // single write 0x84, 0x5a
        begin_frame();
        chk("wr_miso_oe", miso_oe, 1'b1);
        spi_bits(8'h84, 8, rx);
        chk("wr_cmd_miso", rx, 8'h00);
        spi_bits(8'h5a, 8, rx);
        end_frame();
        chk("wr_count", wa.size(), 1);
        chk("wr_addr", wa[0], 5'h04);
        chk("wr_data", wd[0], 8'h5a);
        chk("wr_reads", rd_cnt, 0);
        chk("wr_oe_idle", miso_oe, 1'b0);

        // read 0x0c plus one dummy byte
        begin_frame();
        spi_bits(8'h0c, 8, rx);
        chk("rd_cmd_miso", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        end_frame();
        chk("rd_data", rx, 8'hc3);
        chk("rd_count", rd_cnt, 1);
        chk("rd_writes", wa.size(), 0);

        // streaming writes to TX
        begin_frame();
        spi_bits(8'h95, 8, rx);
        spi_bits(8'h11, 8, rx);
        chk("st_miso", rx, 8'h00);
        spi_bits(8'h22, 8, rx);
        spi_bits(8'h33, 8, rx);
        end_frame();
        chk("st_count", wa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("st_addr", wa[i], 5'h15);
            chk("st_data", wd[i], 8'(8'h11 * (i + 1)));
        end

        // multi-byte write to 0x0c
        begin_frame();
        spi_bits(8'h8c, 8, rx);
        spi_bits(8'ha1, 8, rx);
        spi_bits(8'hb2, 8, rx);
        spi_bits(8'hc3, 8, rx);
        spi_bits(8'hd4, 8, rx);
        end_frame();
        chk("inc_count", wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef CD_SPI_ADDR_INC_EN
            chk("inc_addr", wa[i], 5'(5'h0c + i));
`else
            chk("inc_addr", wa[i], 5'h0c);
`endif
            chk("inc_data", wd[i], 8'(8'ha1 + 8'h11 * i));
        end

        // nss rises after 5 bits of a data byte
        begin_frame();
        spi_bits(8'h84, 8, rx);
        spi_bits(8'hff, 5, rx);
        end_frame();
        chk("abort_writes", wa.size(), 0);
        chk("abort_reads", rd_cnt, 0);
        begin_frame();
        spi_bits(8'h83, 8, rx);
        spi_bits(8'h77, 8, rx);
        end_frame();
        chk("post_abort_count", wa.size(), 1);
        chk("post_abort_addr", wa[0], 5'h03);
        chk("post_abort_data", wd[0], 8'h77);

        // reset during the 3rd bit of a write data byte
        begin_frame();
        spi_bits(8'h84, 8, rx);
        spi_bits(8'hff, 2, rx);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_miso", miso, 1'b0);
        chk("mid_rst_oe", miso_oe, 1'b0);
        chk("mid_rst_addr", csr_address, 5'h00);
        chk("mid_rst_read", csr_read, 1'b0);
        chk("mid_rst_write", csr_write, 1'b0);
        chk("mid_rst_wdata", csr_writedata, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h42, 8, rx);
        end_frame();
        chk("post_rst_writes", wa.size(), 0);
        chk("post_rst_reads", rd_cnt, 0);
        chk("post_rst_addr", csr_address, 5'h00);
        begin_frame();
        spi_bits(8'h86, 8, rx);
        spi_bits(8'h3c, 8, rx);
        end_frame();
        chk("fresh_count", wa.size(), 1);
        chk("fresh_addr", wa[0], 5'h06);
        chk("fresh_data", wd[0], 8'h3c);

        chk("strobe_spacing", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
